// File: rtl/npc_pkg.sv
// Shared fetch-side definitions: fetch state encoding and well-known instruction words.
package npc_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
  localparam logic [31:0] NOP              = 32'h0000_0013;
  localparam logic [31:0] INST_EBREAK      = 32'h0010_0073;

endpackage

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, keeps one imem read in flight and hands
// each fetched word with its PC to decode; redirects squash wrong-path responses.
module ifu_fetch
  import npc_pkg::*;
#(
  parameter int unsigned       XLEN     = 32,
  parameter logic [XLEN-1:0]   RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            halt,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc
);

  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(2'b11);
  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(3'd4);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] inst_buf_q, inst_buf_d;
  logic            drop_q, drop_d;
  logic            req_fire_s;

  // Request handshake uses the same halt gating as the visible request valid.
  assign req_fire_s = (state_q == S_REQ) && !halt && imem_req_ready;

  // State, PC, drop flag and instruction buffer registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      inst_buf_q <= XLEN'(NOP);
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inst_buf_q <= inst_buf_d;
      drop_q     <= drop_d;
    end
  end

  // Next-state logic; a redirect overrides the PC in every state.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inst_buf_d = inst_buf_q;
    drop_d     = drop_q;
    case (state_q)
      S_REQ: begin
        if (req_fire_s) begin
          state_d = S_WAIT;
          // The address already sent is stale if a redirect lands with it.
          drop_d  = redirect_valid;
        end else begin
          state_d = S_REQ;
        end
      end
      S_WAIT: begin
        if (imem_resp_valid) begin
          if (drop_q || redirect_valid) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            inst_buf_d = imem_resp_data;
            state_d    = S_HOLD;
          end
        end else if (redirect_valid) begin
          drop_d = 1'b1;
        end else begin
          drop_d = drop_q;
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          state_d = S_REQ;
        end else if (inst_ready) begin
          pc_d    = pc_q + PC_STEP;
          state_d = S_REQ;
        end else begin
          state_d = S_HOLD;
        end
      end
      default: begin
        state_d = S_REQ;
        drop_d  = 1'b0;
      end
    endcase
    if (redirect_valid) begin
      pc_d = redirect_pc & ALIGN_MASK;
    end else begin
      pc_d = pc_d;
    end
  end

  // Outputs decode from registered state only (halt is the sole input gate).
  always_comb begin
    imem_req_valid = 1'b0;
    inst_valid     = 1'b0;
    case (state_q)
      S_REQ:   imem_req_valid = !halt;
      S_WAIT:  imem_req_valid = 1'b0;
      S_HOLD:  inst_valid     = 1'b1;
      default: imem_req_valid = 1'b0;
    endcase
    imem_req_addr = pc_q;
    inst          = inst_buf_q;
    inst_pc       = pc_q;
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch with a small in-order instruction memory model.
module tb_ifu_fetch;

  logic        clk;
  logic        rst_n;
  logic        halt;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  int total_cnt;
  int bad_cnt;

  // memory model state
  int          lat;
  logic        pend;
  int          wait_cnt;
  logic [31:0] pdata;
  logic        ovr_en;
  logic [31:0] ovr_data;

  ifu_fetch dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .halt            (halt),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst            (inst),
    .inst_pc         (inst_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h8000_0000: mem_word = 32'h0010_0093;
      32'h8000_0004: mem_word = 32'h0020_0113;
      32'h8000_0100: mem_word = 32'h0030_0193;
      32'h8000_0200: mem_word = 32'h0040_0213;
      32'hFFFF_FFFC: mem_word = 32'h0050_0293;
      32'h0000_0000: mem_word = 32'h0060_0313;
      default:       mem_word = 32'h0000_0013;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; the memory model samples the request before the edge
  // and updates its response 1 time unit after it.
  task automatic tick();
    logic        fire;
    logic [31:0] addr;
    logic        rst_s;
    #1;
    fire  = (imem_req_valid === 1'b1) && imem_req_ready;
    addr  = imem_req_addr;
    rst_s = rst_n;
    @(posedge clk);
    #1;
    if (!rst_s) begin
      pend            = 1'b0;
      imem_resp_valid = 1'b0;
      imem_resp_data  = 32'h0;
    end else begin
      if (imem_resp_valid) pend = 1'b0;
      if (fire) begin
        pend     = 1'b1;
        wait_cnt = lat - 1;
        pdata    = ovr_en ? ovr_data : mem_word(addr);
      end else if (pend && wait_cnt > 0) begin
        wait_cnt--;
      end
      imem_resp_valid = pend && (wait_cnt == 0);
      imem_resp_data  = imem_resp_valid ? pdata : 32'h0;
    end
  endtask

  initial begin
    total_cnt = 0;
    bad_cnt   = 0;
    lat = 1; pend = 1'b0; wait_cnt = 0; pdata = 32'h0;
    ovr_en = 1'b0; ovr_data = 32'h0;
    rst_n = 1'b0; halt = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    imem_req_ready = 1'b1; imem_resp_valid = 1'b0; imem_resp_data = 32'h0;
    inst_ready = 1'b0;

    tick(); tick();
    rst_n = 1'b1;
    chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("rst_req_addr", imem_req_addr, 32'h8000_0000);
    chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);

    // first fetch, 1-cycle memory
    tick();
    chk("wait_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("wait_inst_valid", {31'd0, inst_valid}, 32'd0);
    tick();
    chk("c3_inst_valid", {31'd0, inst_valid}, 32'd1);
    chk("c3_inst", inst, 32'h0010_0093);
    chk("c3_inst_pc", inst_pc, 32'h8000_0000);

    // decode stalls for 5 cycles
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_inst", inst, 32'h0010_0093);
      chk("stall_pc", inst_pc, 32'h8000_0000);
      chk("stall_req", {31'd0, imem_req_valid}, 32'd0);
    end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    chk("next_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("next_req_addr", imem_req_addr, 32'h8000_0004);

    // redirect while waiting on a 2-cycle response
    lat = 2; ovr_en = 1'b1; ovr_data = 32'hDEAD_BEEF;
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0100;
    tick();
    redirect_valid = 1'b0;
    chk("rw_resp_present", {31'd0, imem_resp_valid}, 32'd1);
    chk("rw_inst_valid", {31'd0, inst_valid}, 32'd0);
    tick();
    chk("rw_drop_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rw_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("rw_req_addr", imem_req_addr, 32'h8000_0100);
    lat = 1; ovr_en = 1'b0;

    // redirect in HOLD with inst_ready also high
    tick(); tick();
    chk("rh_inst", inst, 32'h0030_0193);
    chk("rh_inst_pc", inst_pc, 32'h8000_0100);
    inst_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h8000_0203;
    tick();
    inst_ready = 1'b0; redirect_valid = 1'b0;
    chk("rh_req_addr", imem_req_addr, 32'h8000_0200);
    chk("rh_inst_valid", {31'd0, inst_valid}, 32'd0);

    // redirect in REQ without handshake, then PC wrap
    imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    imem_req_ready = 1'b1; redirect_valid = 1'b0;
    chk("rq_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("rq_req_addr", imem_req_addr, 32'hFFFF_FFFC);
    tick(); tick();
    chk("wrap_inst", inst, 32'h0050_0293);
    chk("wrap_inst_pc", inst_pc, 32'hFFFF_FFFC);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    chk("wrap_req_addr", imem_req_addr, 32'h0000_0000);

    // redirect coinciding with a request handshake: wrong-path response dropped
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0000;
    tick();
    redirect_valid = 1'b0;
    chk("rqh_req_valid", {31'd0, imem_req_valid}, 32'd0);
    tick();
    chk("rqh_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rqh_req_addr", imem_req_addr, 32'h8000_0000);

    // halt blocks new requests
    halt = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("halt_req_valid", {31'd0, imem_req_valid}, 32'd0);
    end
    halt = 1'b0;
    #1;
    chk("unhalt_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("unhalt_req_addr", imem_req_addr, 32'h8000_0000);

    // reset while a response is outstanding
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mrst_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("mrst_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("mrst_req_addr", imem_req_addr, 32'h8000_0000);
    tick(); tick();
    chk("mrst_inst", inst, 32'h0010_0093);
    chk("mrst_inst_pc", inst_pc, 32'h8000_0000);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
